decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised instruction-decode pipeline stage for the 16-bit core. It replaces the combinational decoder, which needed externally supplied one-back and two-back commands. It keeps its own history of FWD_DEPTH previously issued instructions and produces registered control and per-operand forwarding selects. It also interlocks load-use hazards and supports flush and a valid/ready handshake. It sits between the fetch register and the execute stage.

## Interface

- FWD_DEPTH, 2: number of prior issued slots tracked for forwarding (1..4).
- SEL_W, $clog2(FWD_DEPTH+1): width of forwarding selects.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents in_instr.
- in_instr  in  16  instruction word.
- in_ready  out  1  stage accepts in_instr this cycle.
- out_ready  in  1  execute advances this cycle.
- flush  in  1  discard stage and history (taken branch).
- out_valid  out  1  out_* describes a real instruction.
- out_instr  out  16  registered instruction.
- alu_sel  out  4  ALU operation.
- wr_en, wr_addr  out  1, 3  register write enable and address.
- mem_re, mem_we  out  1, 1  load and store.
- pc_load  out  1  branch (10100, 10111).
- cond  out  3  in_instr[10:8] registered.
- fwd_a, fwd_b  out  SEL_W  0 = register file; k = result of instruction k slots back.
- stall_cnt  out  16  saturating load-use stall count.

## Operation

- Fields: op=[15:14], ra=[13:11], rb=[10:8], func=[7:4].
- Writers:
  - ALU (op=11, func≤1100, func∉{0101,0111}) writes rb.
  - LD (op=00) writes ra.
  - LI/ADDI ([15:11]=10000/10001) write rb.
- Reader A (ra): op=11 with func∈{0000..0110,1101}; op=01 (store data).
- Reader B (rb): op=11 with func∈{0000..0101,1000..1011}; op=00; op=01; ADDI.
- alu_sel:
  - op=11: 0101→0001, 0110→1100, otherwise func.
  - op=0x: 0000. 10000: 1100. 10001, 10100, 10111: 0000.
  - Otherwise 1111.
- History: shift register hist[1..FWD_DEPTH] of {writer, dest, is_ld}. hist[1] is the instruction currently in the output register.
- Forwarding: for each reader operand, the select is the smallest k whose hist[k].writer and dest match; 0 if none or if the operand is not read.
- Load-use stall: hist[1].is_ld and its dest matches a read operand of in_instr. In that case stall=1 and in_valid must also be 1.
- in_ready = out_ready & ~stall & ~flush.
- On out_ready=1 (advance), the stage register loads:
  - flush: bubble, and all history cleared to non-writers.
  - in_valid & ~stall: decoded in_instr, out_valid=1, pushed into history.
  - otherwise: bubble (out_valid=0, all controls 0, alu_sel=1111), pushed as a non-writer so distances stay exact.
- out_ready=0: everything holds, including history, and stall_cnt does not increment.
- stall_cnt increments once per advance cycle that inserts a stall bubble, saturating at 16'hFFFF.

## Timing

- Decode latency is 1 cycle: an instruction accepted at edge n appears on out_* after edge n.
- fwd_a/fwd_b are registered with the instruction they belong to.
- Reset (asynchronous, rst_n=0) forces:
  - out_valid, wr_en, mem_re, mem_we, pc_load, fwd_a, fwd_b = 0.
  - out_instr, cond, wr_addr = 0; alu_sel = 1111.
  - History all non-writers; stall_cnt = 0.
- Reset released mid-stream: the first cycle after reset has out_valid=0, and in_ready follows out_ready.
- flush with out_ready=0: the flush is applied regardless of out_ready (flush has priority over hold).
- Stall and flush in the same cycle: flush wins and stall_cnt is not incremented.
- A load-use stall lasts exactly one bubble. The dependent instruction then forwards with select 2.

## Configuration

- DECODE_LOAD_USE_EN defined: load-use interlock and stall_cnt as above.
- Not defined: stall is tied to 0 and LD forwards like any writer (software schedules loads). stall_cnt is tied to 0.

## Test plan

- 16'hC805 (ALU, ra=1, rb=0, writes r0), then 16'hC001 (reads rb=0) back-to-back → second output has fwd_b=1, out_valid=1 one cycle after acceptance.
- Writer to r3, then unrelated instruction, then reader of r3, with FWD_DEPTH=2 → fwd=2. Repeat with FWD_DEPTH=1 → fwd=0.
- With the macro defined: LD r2 (16'h1000), then reader of r2 → in_ready=0 for one cycle, one bubble, dependent instruction issues with fwd=2, stall_cnt=1.
- Same sequence without the macro → no bubble, fwd=1, stall_cnt=0.
- out_ready=0 for 3 cycles mid-stream → all outputs, history and stall_cnt hold; results are identical after resume.
- flush asserted with a writer in hist[1], followed by a reader → out_valid=0 after the flush, and the reader gets fwd=0. A forced 16'hFFFF preload of the count saturates and does not wrap.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode stage for the 16-bit core.
// Tracks the last FWD_DEPTH issued slots to produce per-operand forwarding
// selects, and supports flush plus a valid/ready handshake.
// Optional feature macro: DECODE_LOAD_USE_EN (load-use interlock and
// saturating stall counter). Without it, loads forward like any writer.
module decode_stage #(
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [15:0]      in_instr,
  output logic             in_ready,
  input  logic             out_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [15:0]      out_instr,
  output logic [3:0]       alu_sel,
  output logic             wr_en,
  output logic [2:0]       wr_addr,
  output logic             mem_re,
  output logic             mem_we,
  output logic             pc_load,
  output logic [2:0]       cond,
  output logic [SEL_W-1:0] fwd_a,
  output logic [SEL_W-1:0] fwd_b,
  output logic [15:0]      stall_cnt
);

  typedef struct packed {
    logic             valid;
    logic [15:0]      instr;
    logic [3:0]       alu;
    logic             wr_en;
    logic [2:0]       wr_addr;
    logic             mem_re;
    logic             mem_we;
    logic             pc_load;
    logic [2:0]       cond;
    logic [SEL_W-1:0] fwd_a;
    logic [SEL_W-1:0] fwd_b;
  } stage_t;

  // Instruction fields
  logic [1:0] op;
  logic [2:0] ra;
  logic [2:0] rb;
  logic [3:0] func;
  logic [4:0] top5;

  assign op   = in_instr[15:14];
  assign ra   = in_instr[13:11];
  assign rb   = in_instr[10:8];
  assign func = in_instr[7:4];
  assign top5 = in_instr[15:11];

  // Decoded attributes of in_instr
  logic       dec_wr;
  logic [2:0] dec_dst;
  logic       rd_a;
  logic       rd_b;
  logic [3:0] dec_alu;

  // History: index 0 is the instruction currently in the output register
  logic [FWD_DEPTH-1:0] hist_wr_q;
  logic [FWD_DEPTH-1:0] hist_wr_d;
  logic [2:0]           hist_dst_q [FWD_DEPTH];
  logic [2:0]           hist_dst_d [FWD_DEPTH];

  logic [SEL_W-1:0] fwd_a_d;
  logic [SEL_W-1:0] fwd_b_d;
  logic             stall;
  logic             take;

  stage_t stage_q;
  stage_t stage_d;
  stage_t dec_stage;
  stage_t bubble;

  // Classify in_instr: writer/destination, operand reads and ALU operation
  always_comb begin
    dec_wr  = 1'b0;
    dec_dst = rb;
    rd_a    = 1'b0;
    rd_b    = 1'b0;
    dec_alu = 4'b1111;
    case (op)
      2'b11: begin
        dec_wr  = (func <= 4'b1100) && (func != 4'b0101) && (func != 4'b0111);
        dec_dst = rb;
        rd_a    = (func <= 4'b0110) || (func == 4'b1101);
        rd_b    = (func <= 4'b0101) || ((func >= 4'b1000) && (func <= 4'b1011));
        case (func)
          4'b0101: dec_alu = 4'b0001;
          4'b0110: dec_alu = 4'b1100;
          default: dec_alu = func;
        endcase
      end
      2'b00: begin
        dec_wr  = 1'b1;
        dec_dst = ra;
        rd_b    = 1'b1;
        dec_alu = 4'b0000;
      end
      2'b01: begin
        rd_a    = 1'b1;
        rd_b    = 1'b1;
        dec_alu = 4'b0000;
      end
      default: begin
        case (top5)
          5'b10000: begin
            dec_wr  = 1'b1;
            dec_dst = rb;
            dec_alu = 4'b1100;
          end
          5'b10001: begin
            dec_wr  = 1'b1;
            dec_dst = rb;
            rd_b    = 1'b1;
            dec_alu = 4'b0000;
          end
          5'b10100, 5'b10111: dec_alu = 4'b0000;
          default:            dec_alu = 4'b1111;
        endcase
      end
    endcase
  end

  // Forwarding select: nearest history slot that writes the operand register
  always_comb begin
    logic found_a;
    logic found_b;
    fwd_a_d = '0;
    fwd_b_d = '0;
    found_a = 1'b0;
    found_b = 1'b0;
    for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
      if (!found_a && rd_a && hist_wr_q[k] && (hist_dst_q[k] == ra)) begin
        fwd_a_d = SEL_W'(k + 1);
        found_a = 1'b1;
      end
      if (!found_b && rd_b && hist_wr_q[k] && (hist_dst_q[k] == rb)) begin
        fwd_b_d = SEL_W'(k + 1);
        found_b = 1'b1;
      end
    end
  end

`ifdef DECODE_LOAD_USE_EN
  logic [FWD_DEPTH-1:0] hist_ld_q;
  logic [FWD_DEPTH-1:0] hist_ld_d;
  logic                 dec_is_ld;
  logic [15:0]          stall_cnt_q;
  logic [15:0]          stall_cnt_d;

  assign dec_is_ld = (op == 2'b00);

  // Load in the output register feeding an operand of the incoming instruction
  assign stall = in_valid && hist_wr_q[0] && hist_ld_q[0] &&
                 ((rd_a && (hist_dst_q[0] == ra)) || (rd_b && (hist_dst_q[0] == rb)));
`else
  assign stall = 1'b0;
`endif

  assign in_ready = out_ready & ~stall & ~flush;
  assign take     = in_valid & ~stall;

  // Build the decoded stage contents and the bubble pattern
  always_comb begin
    bubble               = '0;
    bubble.alu           = 4'b1111;
    dec_stage            = '0;
    dec_stage.valid      = 1'b1;
    dec_stage.instr      = in_instr;
    dec_stage.alu        = dec_alu;
    dec_stage.wr_en      = dec_wr;
    dec_stage.wr_addr    = dec_wr ? dec_dst : 3'd0;
    dec_stage.mem_re     = (op == 2'b00);
    dec_stage.mem_we     = (op == 2'b01);
    dec_stage.pc_load    = (top5 == 5'b10100) || (top5 == 5'b10111);
    dec_stage.cond       = rb;
    dec_stage.fwd_a      = fwd_a_d;
    dec_stage.fwd_b      = fwd_b_d;
  end

  // Next stage/history: flush over advance over hold; bubbles push non-writers
  always_comb begin
    stage_d    = stage_q;
    hist_wr_d  = hist_wr_q;
    hist_dst_d = hist_dst_q;
`ifdef DECODE_LOAD_USE_EN
    hist_ld_d  = hist_ld_q;
`endif
    if (flush) begin
      stage_d    = bubble;
      hist_wr_d  = '0;
      hist_dst_d = '{default: '0};
`ifdef DECODE_LOAD_USE_EN
      hist_ld_d  = '0;
`endif
    end else if (out_ready) begin
      stage_d = take ? dec_stage : bubble;
      for (int unsigned k = 1; k < FWD_DEPTH; k++) begin
        hist_wr_d[k]  = hist_wr_q[k-1];
        hist_dst_d[k] = hist_dst_q[k-1];
`ifdef DECODE_LOAD_USE_EN
        hist_ld_d[k]  = hist_ld_q[k-1];
`endif
      end
      hist_wr_d[0]  = take & dec_wr;
      hist_dst_d[0] = dec_dst;
`ifdef DECODE_LOAD_USE_EN
      hist_ld_d[0]  = take & dec_is_ld;
`endif
    end
  end

  // Stage and history registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q     <= '0;
      stage_q.alu <= 4'b1111;
      hist_wr_q   <= '0;
      hist_dst_q  <= '{default: '0};
    end else begin
      stage_q    <= stage_d;
      hist_wr_q  <= hist_wr_d;
      hist_dst_q <= hist_dst_d;
    end
  end

`ifdef DECODE_LOAD_USE_EN
  // Load flags of history slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_ld_q <= '0;
    else        hist_ld_q <= hist_ld_d;
  end

  // Count stall bubbles inserted on advance cycles, saturating
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!flush && out_ready && stall && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

  assign out_valid = stage_q.valid;
  assign out_instr = stage_q.instr;
  assign alu_sel   = stage_q.alu;
  assign wr_en     = stage_q.wr_en;
  assign wr_addr   = stage_q.wr_addr;
  assign mem_re    = stage_q.mem_re;
  assign mem_we    = stage_q.mem_we;
  assign pc_load   = stage_q.pc_load;
  assign cond      = stage_q.cond;
  assign fwd_a     = stage_q.fwd_a;
  assign fwd_b     = stage_q.fwd_b;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized and directed checks of decode_stage against a
// rule-level reference model (issue log + decode rules). Two instances share
// the stimulus: FWD_DEPTH=2 and FWD_DEPTH=1.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        out_ready;
  logic        flush;

  logic        in_ready,  in_ready1;
  logic        out_valid, out_valid1;
  logic [15:0] out_instr, out_instr1;
  logic [3:0]  alu_sel,   alu_sel1;
  logic        wr_en,     wr_en1;
  logic [2:0]  wr_addr,   wr_addr1;
  logic        mem_re,    mem_re1;
  logic        mem_we,    mem_we1;
  logic        pc_load,   pc_load1;
  logic [2:0]  cond,      cond1;
  logic [1:0]  fwd_a,     fwd_b;
  logic [0:0]  fwd_a1,    fwd_b1;
  logic [15:0] stall_cnt, stall_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.FWD_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .out_ready(out_ready), .flush(flush),
    .out_valid(out_valid), .out_instr(out_instr), .alu_sel(alu_sel),
    .wr_en(wr_en), .wr_addr(wr_addr), .mem_re(mem_re), .mem_we(mem_we),
    .pc_load(pc_load), .cond(cond), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt)
  );

  decode_stage #(.FWD_DEPTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready1), .out_ready(out_ready), .flush(flush),
    .out_valid(out_valid1), .out_instr(out_instr1), .alu_sel(alu_sel1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .mem_re(mem_re1), .mem_we(mem_we1),
    .pc_load(pc_load1), .cond(cond1), .fwd_a(fwd_a1), .fwd_b(fwd_b1),
    .stall_cnt(stall_cnt1)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit        v;
    bit [15:0] instr;
    bit [3:0]  alu;
    bit        we;
    bit [2:0]  wa;
    bit        re;
    bit        st;
    bit        pc;
    bit [2:0]  cond;
    int        fa2, fb2, fa1, fb1;
  } exp_t;

  int          log_q[$];   // issued slots, newest first; -1 marks a non-writer slot
  exp_t        e;
  int unsigned cnt;
  bit          seen_rdy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dest_of(input logic [15:0] i);
    int f;
    f = int'(i[7:4]);
    if (i[15:14] == 2'b11 && f <= 12 && f != 5 && f != 7) return int'(i[10:8]);
    if (i[15:14] == 2'b00) return int'(i[13:11]);
    if (i[15:11] == 5'b10000 || i[15:11] == 5'b10001) return int'(i[10:8]);
    return -1;
  endfunction

  function automatic bit reads_a(input logic [15:0] i);
    int f;
    f = int'(i[7:4]);
    return (i[15:14] == 2'b11 && (f <= 6 || f == 13)) || (i[15:14] == 2'b01);
  endfunction

  function automatic bit reads_b(input logic [15:0] i);
    int f;
    f = int'(i[7:4]);
    return (i[15:14] == 2'b11 && (f <= 5 || (f >= 8 && f <= 11))) ||
           (i[15:14] == 2'b00) || (i[15:14] == 2'b01) || (i[15:11] == 5'b10001);
  endfunction

  function automatic int alu_of(input logic [15:0] i);
    int f;
    f = int'(i[7:4]);
    if (i[15:14] == 2'b11) return (f == 5) ? 1 : (f == 6) ? 12 : f;
    if (i[15] == 1'b0) return 0;
    if (i[15:11] == 5'b10000) return 12;
    if (i[15:11] == 5'b10001 || i[15:11] == 5'b10100 || i[15:11] == 5'b10111) return 0;
    return 15;
  endfunction

  function automatic int fwd_m(input int depth, input int rg);
    logic [15:0] w;
    for (int k = 1; k <= depth; k++) begin
      if (k <= log_q.size() && log_q[k-1] >= 0) begin
        w = 16'(log_q[k-1]);
        if (dest_of(w) == rg) return k;
      end
    end
    return 0;
  endfunction

  function automatic bit ld_use_m(input bit v, input logic [15:0] i);
`ifdef DECODE_LOAD_USE_EN
    logic [15:0] p;
    int d;
    if (!v || log_q.size() == 0 || log_q[0] < 0) return 1'b0;
    p = 16'(log_q[0]);
    if (p[15:14] != 2'b00) return 1'b0;
    d = int'(p[13:11]);
    return (reads_a(i) && int'(i[13:11]) == d) || (reads_b(i) && int'(i[10:8]) == d);
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t bubble_m();
    exp_t r;
    r = '{default: 0};
    r.alu = 4'hF;
    return r;
  endfunction

  function automatic exp_t decode_m(input logic [15:0] i);
    exp_t r;
    int d;
    d = dest_of(i);
    r.v     = 1'b1;
    r.instr = i;
    r.alu   = 4'(alu_of(i));
    r.we    = (d >= 0);
    r.wa    = (d >= 0) ? 3'(d) : 3'd0;
    r.re    = (i[15:14] == 2'b00);
    r.st    = (i[15:14] == 2'b01);
    r.pc    = (i[15:11] == 5'b10100) || (i[15:11] == 5'b10111);
    r.cond  = i[10:8];
    r.fa2   = reads_a(i) ? fwd_m(2, int'(i[13:11])) : 0;
    r.fb2   = reads_b(i) ? fwd_m(2, int'(i[10:8]))  : 0;
    r.fa1   = reads_a(i) ? fwd_m(1, int'(i[13:11])) : 0;
    r.fb1   = reads_b(i) ? fwd_m(1, int'(i[10:8]))  : 0;
    return r;
  endfunction

  task automatic model_reset();
    log_q.delete();
    e   = bubble_m();
    cnt = 0;
  endtask

  task automatic model_edge();
    bit stl;
    stl = ld_use_m(in_valid, in_instr);
    if (flush) begin
      e = bubble_m();
      log_q.delete();
    end else if (out_ready) begin
      if (in_valid && !stl) begin
        e = decode_m(in_instr);
        log_q.push_front(int'(in_instr));
      end else begin
        e = bubble_m();
        log_q.push_front(-1);
        if (stl && cnt != 32'hFFFF) cnt++;
      end
      if (log_q.size() > 4) void'(log_q.pop_back());
    end
  endtask

  task automatic check_outputs();
    chk("out_valid",  out_valid,  e.v);
    chk("out_instr",  out_instr,  e.instr);
    chk("alu_sel",    alu_sel,    e.alu);
    chk("wr_en",      wr_en,      e.we);
    chk("wr_addr",    wr_addr,    e.wa);
    chk("mem_re",     mem_re,     e.re);
    chk("mem_we",     mem_we,     e.st);
    chk("pc_load",    pc_load,    e.pc);
    chk("cond",       cond,       e.cond);
    chk("fwd_a",      fwd_a,      e.fa2);
    chk("fwd_b",      fwd_b,      e.fb2);
    chk("stall_cnt",  stall_cnt,  cnt);
    chk("out_valid1", out_valid1, e.v);
    chk("out_instr1", out_instr1, e.instr);
    chk("fwd_a1",     fwd_a1,     e.fa1);
    chk("fwd_b1",     fwd_b1,     e.fb1);
    chk("stall_cnt1", stall_cnt1, cnt);
  endtask

  // One cycle: drive at negedge, check in_ready, clock, check registered outputs
  task automatic step(input bit v, input logic [15:0] ins, input bit ordy, input bit fl);
    bit exp_rdy;
    in_valid  = v;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    #1;
    exp_rdy  = ordy && !ld_use_m(v, ins) && !fl;
    seen_rdy = in_ready;
    chk("in_ready",  in_ready,  exp_rdy);
    chk("in_ready1", in_ready1, exp_rdy);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  // Present an instruction until the stage takes it (bounded)
  task automatic issue(input logic [15:0] ins, output int tries);
    tries = 0;
    do begin
      step(1'b1, ins, 1'b1, 1'b0);
      tries++;
    end while (!seen_rdy && tries < 8);
    if (!seen_rdy) chk("issue_bound", seen_rdy, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("rst_alu_sel", alu_sel, 4'hF);
    chk("rst_valid",   out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Load-use: LD r2 then a reader of r2
    issue(16'h1000, t);
    issue(16'hC200, t);
`ifdef DECODE_LOAD_USE_EN
    chk("ldu_tries", t, 2);
    chk("ldu_fwd_b", fwd_b, 2);
    chk("ldu_fwd_b1", fwd_b1, 0);
    chk("ldu_cnt", stall_cnt, 1);
`else
    chk("ldu_tries", t, 1);
    chk("ldu_fwd_b", fwd_b, 1);
    chk("ldu_fwd_b1", fwd_b1, 1);
    chk("ldu_cnt", stall_cnt, 0);
`endif
    chk("ldu_valid", out_valid, 1);

    // Back-to-back ALU writer and reader of r0
    issue(16'hC805, t);
    issue(16'hC001, t);
    chk("b2b_fwd_b", fwd_b, 1);
    chk("b2b_valid", out_valid, 1);

    // Writer r3, unrelated branch, reader of r3
    issue(16'hC300, t);
    issue(16'hA000, t);
    issue(16'hD800, t);
    chk("dist2_fwd_a",  fwd_a, 2);
    chk("dist2_fwd_a1", fwd_a1, 0);

    // Hold for three cycles keeps history distances
    issue(16'hC300, t);
    repeat (3) step(1'b1, 16'hD800, 1'b0, 1'b0);
    issue(16'hD800, t);
    chk("hold_fwd_a", fwd_a, 1);

    // Flush with a writer in the output register
    issue(16'hC805, t);
    step(1'b1, 16'hC001, 1'b1, 1'b1);
    chk("flush_valid", out_valid, 0);
    issue(16'hC001, t);
    chk("flush_fwd_b", fwd_b, 0);

    // Flush while out_ready=0
    issue(16'hC805, t);
    step(1'b1, 16'hC001, 1'b0, 1'b1);
    chk("flush_hold_valid", out_valid, 0);
    issue(16'hC001, t);
    chk("flush_hold_fwd_b", fwd_b, 0);

    // Stall and flush in the same cycle
    issue(16'h1000, t);
    step(1'b1, 16'hC200, 1'b1, 1'b1);
    issue(16'hC200, t);

    // Asynchronous reset mid-stream
    issue(16'hC805, t);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("arst_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'hC001, 1'b1, 1'b0);
    chk("arst_fwd_b", fwd_b, 0);

`ifdef DECODE_LOAD_USE_EN
    // Saturation from a preloaded count
    force dut.stall_cnt_q  = 16'hFFFF;
    force dut1.stall_cnt_q = 16'hFFFF;
    cnt = 32'hFFFF;
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    release dut.stall_cnt_q;
    release dut1.stall_cnt_q;
    issue(16'h1000, t);
    issue(16'hC200, t);
    chk("sat_cnt", stall_cnt, 16'hFFFF);
`endif

    // Randomized traffic with a small register pool to provoke hazards
    for (int n = 0; n < 800; n++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        ins[13:11] = 3'($urandom_range(0, 3));
        ins[10:8]  = 3'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) == 0) ins[15:14] = 2'b00;
      step($urandom_range(0, 9) < 8, ins, $urandom_range(0, 9) < 8, $urandom_range(0, 24) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
